// File: rtl/riscV_unrn_pkg.sv
// Shared constants and types for the machine-mode trap controller.
package riscV_unrn_pkg;

  localparam logic [11:0] CSR_MSTATUS  = 12'h300;
  localparam logic [11:0] CSR_MIE      = 12'h304;
  localparam logic [11:0] CSR_MTVEC    = 12'h305;
  localparam logic [11:0] CSR_MSCRATCH = 12'h340;
  localparam logic [11:0] CSR_MEPC     = 12'h341;
  localparam logic [11:0] CSR_MCAUSE   = 12'h342;
  localparam logic [11:0] CSR_MTVAL    = 12'h343;
  localparam logic [11:0] CSR_MIP      = 12'h344;

  localparam logic [31:0] M_TIMER_INT = 32'h8000_0007;

  localparam int MIE_BIT  = 3;
  localparam int MPIE_BIT = 7;
  localparam int MTIE_BIT = 7;

  typedef enum logic [1:0] {RUN, DRAIN, REDIRECT} trap_state_t;

endpackage

// File: rtl/trap_csr_file.sv
// M-mode trap CSR storage: field masking, read mux, commit-stage writes and trap/mret updates.
module trap_csr_file
  import riscV_unrn_pkg::*;
#(
  parameter logic [31:0] MTVEC_RESET = 32'h0000_0100
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        timer_irq_i,
  input  logic [11:0] addr_i,
  input  logic        we_i,
  input  logic [31:0] wdata_i,
  input  logic        trap_i,
  input  logic [31:0] trap_pc_i,
  input  logic [31:0] trap_cause_i,
  input  logic [31:0] trap_val_i,
  input  logic        mret_i,
  output logic [31:0] rdata_o,
  output logic [31:0] mtvec_o,
  output logic [31:0] mepc_o,
  output logic        mie_o,
  output logic        mtie_o
);

  logic        st_mie, st_mpie, mtie;
  logic [29:0] mtvec, mepc;
  logic [31:0] mcause, mtval, mscratch;

  // Trap/mret updates take precedence; the caller already drops we_i on those cycles.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st_mie   <= 1'b0;
      st_mpie  <= 1'b0;
      mtie     <= 1'b0;
      mtvec    <= MTVEC_RESET[31:2];
      mepc     <= '0;
      mcause   <= '0;
      mtval    <= '0;
      mscratch <= '0;
    end else if (trap_i) begin
      mepc    <= trap_pc_i[31:2];
      mcause  <= trap_cause_i;
      mtval   <= trap_val_i;
      st_mpie <= st_mie;
      st_mie  <= 1'b0;
    end else if (mret_i) begin
      st_mie  <= st_mpie;
      st_mpie <= 1'b1;
    end else if (we_i) begin
      case (addr_i)
        CSR_MSTATUS: begin
          st_mie  <= wdata_i[MIE_BIT];
          st_mpie <= wdata_i[MPIE_BIT];
        end
        CSR_MIE:      mtie     <= wdata_i[MTIE_BIT];
        CSR_MTVEC:    mtvec    <= wdata_i[31:2];
        CSR_MSCRATCH: mscratch <= wdata_i;
        CSR_MEPC:     mepc     <= wdata_i[31:2];
        CSR_MCAUSE:   mcause   <= wdata_i;
        CSR_MTVAL:    mtval    <= wdata_i;
        default: ;
      endcase
    end
  end

  always_comb begin
    rdata_o = '0;
    case (addr_i)
      CSR_MSTATUS: begin
        rdata_o[MIE_BIT]  = st_mie;
        rdata_o[MPIE_BIT] = st_mpie;
        rdata_o[12:11]    = 2'b11;
      end
      CSR_MIE:      rdata_o[MTIE_BIT] = mtie;
      CSR_MIP:      rdata_o[MTIE_BIT] = timer_irq_i;
      CSR_MTVEC:    rdata_o = {mtvec, 2'b00};
      CSR_MSCRATCH: rdata_o = mscratch;
      CSR_MEPC:     rdata_o = {mepc, 2'b00};
      CSR_MCAUSE:   rdata_o = mcause;
      CSR_MTVAL:    rdata_o = mtval;
      default:      rdata_o = '0;
    endcase
  end

  assign mtvec_o = {mtvec, 2'b00};
  assign mepc_o  = {mepc, 2'b00};
  assign mie_o   = st_mie;
  assign mtie_o  = mtie;

endmodule

// File: rtl/trap_ctrl.sv
// Machine-mode trap responder: event priority, drain/redirect FSM and latched redirect target.
module trap_ctrl
  import riscV_unrn_pkg::*;
#(
  parameter int          FLUSH_CYCLES = 2,
  parameter logic [31:0] MTVEC_RESET  = 32'h0000_0100
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        instr_valid_i,
  input  logic [31:0] pc_i,
  input  logic        exc_present_i,
  input  logic [31:0] exc_cause_i,
  input  logic [31:0] trap_info_i,
  input  logic        mret_i,
  input  logic        timer_irq_i,
  input  logic        csr_we_i,
  input  logic [11:0] csr_addr_i,
  input  logic [31:0] csr_wdata_i,
  output logic [31:0] csr_rdata_o,
  output logic        flush_o,
  output logic        stall_o,
  output logic        redirect_valid_o,
  output logic [31:0] redirect_pc_o
);

  localparam int CW = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LOAD = (FLUSH_CYCLES > 0) ? CW'(FLUSH_CYCLES - 1) : '0;

  trap_state_t state, state_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic [31:0] target, mtvec, mepc, rdata;
  logic        mie_en, mtie;
  logic        sample, take_exc, take_mret, take_irq, accept, take_trap, csr_wr;

  assign sample    = !rst && (state == RUN) && instr_valid_i;
  assign take_exc  = sample && exc_present_i;
  assign take_mret = sample && !exc_present_i && mret_i;
  assign take_irq  = sample && !exc_present_i && !mret_i && mie_en && mtie && timer_irq_i;
  assign take_trap = take_exc || take_irq;
  assign accept    = take_trap || take_mret;
  assign csr_wr    = sample && csr_we_i && !accept;

  trap_csr_file #(.MTVEC_RESET(MTVEC_RESET)) u_csr (
    .clk          (clk),
    .rst          (rst),
    .timer_irq_i  (timer_irq_i),
    .addr_i       (csr_addr_i),
    .we_i         (csr_wr),
    .wdata_i      (csr_wdata_i),
    .trap_i       (take_trap),
    .trap_pc_i    (pc_i),
    .trap_cause_i (take_exc ? exc_cause_i : M_TIMER_INT),
    .trap_val_i   (take_exc ? trap_info_i : 32'h0),
    .mret_i       (take_mret),
    .rdata_o      (rdata),
    .mtvec_o      (mtvec),
    .mepc_o       (mepc),
    .mie_o        (mie_en),
    .mtie_o       (mtie)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= RUN;
      cnt    <= '0;
      target <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      // Captured from pre-update CSR values so the same-edge commit cannot leak in.
      if (accept) target <= take_mret ? mepc : mtvec;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      RUN: if (accept) begin
        state_nxt = (FLUSH_CYCLES == 0) ? REDIRECT : DRAIN;
        cnt_nxt   = CNT_LOAD;
      end
      DRAIN: begin
        if (cnt == '0) state_nxt = REDIRECT;
        else           cnt_nxt   = cnt - 1'b1;
      end
      REDIRECT: state_nxt = RUN;
      default:  state_nxt = RUN;
    endcase
  end

  assign flush_o          = take_trap;
  assign stall_o          = !rst && (accept || state != RUN);
  assign redirect_valid_o = !rst && (state == REDIRECT);
  assign redirect_pc_o    = redirect_valid_o ? target : 32'h0;
  assign csr_rdata_o      = rst ? 32'h0 : rdata;

endmodule
